apb_master_req: RTL

- Single-outstanding APB3 initiator. Converts a valid/ready request/response interface into APB SETUP/ACCESS transfers toward peripheral slaves such as the SoC timer, UART and GPIO.
- Sits between a config sequencer or debug module and the APB interconnect.
- Provides wait-state handling, PSLVERR capture and a bounded PREADY timeout, so a hung slave cannot stall the requester.

---
 rtl/apb_master_req.sv | 116 +++++++++++
 1 files changed

// File: rtl/apb_master_req.sv
// Single-outstanding APB3 initiator: turns a valid/ready request into one
// SETUP/ACCESS transfer and returns the result on a valid/ready response port.
module apb_master_req #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic                      req_write_i,
    input  logic [31:0]               req_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      rsp_timeout_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR_o,
    output logic [31:0]               PWDATA_o,
    output logic                      PWRITE_o,
    output logic                      PSEL_o,
    output logic                      PENABLE_o,
    input  logic [31:0]               PRDATA_i,
    input  logic                      PREADY_i,
    input  logic                      PSLVERR_i,
    output logic                      busy_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic              timeout_hit;

    assign timeout_hit = TIMEOUT_EN && (wait_cnt_q == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid_i) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (PREADY_i || timeout_hit) state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields stay latched outside a transfer; response fields hold
    // until the next ACCESS completes so RESP backpressure sees stable data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            PADDR_o       <= '0;
            PWDATA_o      <= '0;
            PWRITE_o      <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        PADDR_o  <= req_addr_i;
                        PWRITE_o <= req_write_i;
                        PWDATA_o <= req_wdata_i;
                    end
                end
                SETUP: begin
                    wait_cnt_q <= '0;
                end
                ACCESS: begin
                    if (PREADY_i) begin
                        rsp_rdata_o   <= PWRITE_o ? 32'h0 : PRDATA_i;
                        rsp_err_o     <= PSLVERR_i;
                        rsp_timeout_o <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_rdata_o   <= 32'h0;
                        rsp_err_o     <= 1'b1;
                        rsp_timeout_o <= 1'b1;
                    end else if (wait_cnt_q != CNT_MAX) begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign PSEL_o      = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE_o   = (state_q == ACCESS);
    assign rsp_valid_o = (state_q == RESP);
    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);

endmodule
